// File: rtl/soc_clk_ctrl.sv
// soc_clk_ctrl: clock-control and reset sequencing between the clock wizard
// and the SoC core.
//   - Synchronises the wizard lock. Holds the core in reset until lock has
//     been stable for HOLD_CYCLES cycles, and re-asserts reset if lock drops.
//   - Generates NUM_CH programmable clock-enable pulses, with a single-step
//     mode for debugging.
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   RST        asynchronous, active-high reset
//   locked     clock-wizard lock (asynchronous to clk)
//   div        per-channel divisor; channel i is div[i*DIV_W +: DIV_W]
//   step_mode  1 = single-step, 0 = free run
//   step       step request (button level, asynchronous)
//   rst_out    active-high reset to the core and peripherals
//   ce         one-cycle clock-enable pulse per channel
//   running    high while in RUN
//   lost_cnt   saturating count of lock losses seen in HOLD or RUN

// Per-channel divider: a down-counter that pulses on zero, or on step edges.
//   i_run        block is in RUN and stays there this cycle
//   i_step_mode  hold the counter; pulse only on i_step_edge
//   i_step_edge  synchronised rising edge of the step button
//   i_div        divisor; it is sampled only when the counter reloads
//   o_ce         registered clock-enable pulse
module soc_clk_ctrl_ch #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_step_mode,
  input  logic             i_step_edge,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_ce
);
  logic [DIV_W-1:0] r_cnt;
  logic             r_ce;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else if (!i_run) begin
      r_cnt <= i_div;
      r_ce  <= 1'b0;
    end else if (i_step_mode) begin
      // The counter freezes, so free run later resumes where it left off.
      r_ce <= i_step_edge;
      if (i_step_edge) r_cnt <= i_div;
    end else if (r_cnt == '0) begin
      r_ce  <= 1'b1;
      r_cnt <= i_div;
    end else begin
      r_ce  <= 1'b0;
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_ce = r_ce;
endmodule

module soc_clk_ctrl #(
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    locked,
  input  logic [NUM_CH*DIV_W-1:0] div,
  input  logic                    step_mode,
  input  logic                    step,
  output logic                    rst_out,
  output logic [NUM_CH-1:0]       ce,
  output logic                    running,
  output logic [7:0]              lost_cnt
);
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_WAIT_LOCK, S_HOLD, S_RUN} state_t;

  state_t          r_state, w_nxt;
  logic [HC_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [7:0]      r_lost_cnt;
  logic            w_lost_inc;
  logic            r_rst_out, r_running;
  logic [1:0]      r_lock_sync;
  // [1] is step_s and [2] is its previous value.
  logic [2:0]      r_step_sync;
  logic            w_locked_s, w_step_edge, w_run;

  assign w_locked_s  = r_lock_sync[1];
  assign w_step_edge = r_step_sync[1] & ~r_step_sync[2];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_lock_sync <= '0;
      r_step_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[0], locked};
      r_step_sync <= {r_step_sync[1:0], step};
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_hold_nxt = r_hold_cnt;
    w_lost_inc = 1'b0;
    case (r_state)
      S_WAIT_LOCK: if (w_locked_s) begin
        w_nxt      = S_HOLD;
        w_hold_nxt = '0;
      end
      S_HOLD: begin
        if (!w_locked_s) begin
          w_nxt      = S_WAIT_LOCK;
          w_lost_inc = 1'b1;
        end else if (r_hold_cnt == HOLD_MAX) begin
          w_nxt = S_RUN;
        end else begin
          w_hold_nxt = r_hold_cnt + HC_W'(1);
        end
      end
      S_RUN: if (!w_locked_s) begin
        w_nxt      = S_WAIT_LOCK;
        w_lost_inc = 1'b1;
      end
      default: w_nxt = S_WAIT_LOCK;
    endcase
  end

  // rst_out and running come from the next state, so they switch on the
  // same edge the state does.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state    <= S_WAIT_LOCK;
      r_hold_cnt <= '0;
      r_lost_cnt <= '0;
      r_rst_out  <= 1'b1;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_hold_cnt <= w_hold_nxt;
      if (w_lost_inc && r_lost_cnt != 8'hFF) r_lost_cnt <= r_lost_cnt + 8'd1;
      r_rst_out  <= (w_nxt != S_RUN);
      r_running  <= (w_nxt == S_RUN);
    end
  end

  // Channels count only while RUN persists. On the edge that leaves RUN,
  // ce drops together with rst_out rising.
  assign w_run = (r_state == S_RUN) && (w_nxt == S_RUN);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    soc_clk_ctrl_ch #(.DIV_W(DIV_W)) u_ch (
      .clk         (clk),
      .rst         (RST),
      .i_run       (w_run),
      .i_step_mode (step_mode),
      .i_step_edge (w_step_edge),
      .i_div       (div[g*DIV_W +: DIV_W]),
      .o_ce        (ce[g])
    );
  end

  assign rst_out  = r_rst_out;
  assign running  = r_running;
  assign lost_cnt = r_lost_cnt;
endmodule

// File: doc/soc_clk_ctrl.md
# soc_clk_ctrl

Clock-control and reset-sequencing block that sits between the clock wizard and the SoC core, replacing the bare `locked`-ignored hookup. It synchronises the wizard's `locked` output, holds the core in reset until the clock has been stable for a parametrised number of cycles, and re-asserts reset if lock is lost. It also generates `NUM_CH` independent, runtime-programmable clock-enable pulses for the 65C02 core and peripherals, with a single-step mode for debugging.

## Interface
- `HOLD_CYCLES`, 16: cycles with lock stable before reset release; ≥1.
- `NUM_CH`, 2: number of clock-enable channels; ≥1.
- `DIV_W`, 8: width of each channel divisor.
- `clk`  in  1  system clock (clock wizard output); all logic is on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `locked`  in  1  clock-wizard lock; asynchronous to `clk`.
- `div`  in  NUM_CH*DIV_W  divisor per channel; channel i occupies bits [i*DIV_W +: DIV_W].
- `step_mode`  in  1  1 = single-step; 0 = free run.
- `step`  in  1  step request (button level; asynchronous).
- `rst_out`  out  1  active-high reset to the core and peripherals.
- `ce`  out  NUM_CH  one-cycle clock-enable pulse per channel.
- `running`  out  1  high while in the RUN state.
- `lost_cnt`  out  8  saturating count of lock losses seen in HOLD or RUN.

## Operation
- `locked` and `step` each pass through a 2-flop synchroniser; `locked_s` and `step_s` are the synchronised values. Step edge: `step_s`=1 and previous `step_s`=0.
- FSM states: WAIT_LOCK, HOLD, RUN.
  - WAIT_LOCK: if `locked_s`, go to HOLD and clear `hold_cnt`.
  - HOLD: if !`locked_s`, go to WAIT_LOCK and increment `lost_cnt`. Else if `hold_cnt`==HOLD_CYCLES-1, go to RUN. Else increment `hold_cnt`.
  - RUN: if !`locked_s`, go to WAIT_LOCK and increment `lost_cnt`.
- `lost_cnt` saturates at 255; only `RST` clears it.
- `rst_out` and `running` are registered. `rst_out` is 1 in any state other than RUN; `running` is 1 only in RUN.
- Each channel i has a down-counter `cnt[i]` (DIV_W bits) and a divisor d = `div[i]`.
  - Outside RUN: `cnt[i]` loads d; `ce[i]` is 0.
  - RUN, free-run mode: if `cnt[i]`==0, then `ce[i]`=1 and `cnt[i]` reloads d (sampled at the reload cycle). Else `ce[i]`=0 and `cnt[i]` decrements. This gives one pulse every d+1 cycles; d=0 gives `ce` high continuously.
  - RUN, `step_mode`=1: counters hold their value. Each step edge gives exactly one `ce` pulse on every channel at once, and all counters reload their divisors. There are no other pulses.
  - `step_mode` 1→0: free running resumes from the held counter values.
- Divisor changes take effect at the next reload and never truncate a period already in progress.

## Timing
- `RST` asserted (asynchronous): state=WAIT_LOCK, `rst_out`=1, `ce`=0, `running`=0, `lost_cnt`=0, `hold_cnt`=0, synchronisers=0, `cnt`=0.
- `RST` deasserts while `locked` is already high: `locked_s` rises at edge 2. HOLD is entered at edge 3 and RUN at edge 3+HOLD_CYCLES. `rst_out` falls and `running` rises at that same edge.
- First `ce[i]` in free run: d+1 edges after RUN is entered.
- `locked` drops in RUN: after 2 synchroniser edges plus 1, `rst_out`=1 and `ce`=0. `lost_cnt` increments on that same edge.
- Lock glitch during HOLD restarts the hold count from zero once lock returns.
- Step latency: a step edge gives a `ce` pulse 3 edges after `step` rises, at synchroniser plus edge-detect depth. `step` held high gives exactly one pulse.
- A step edge outside RUN is ignored and does not queue.

## Test plan
- Power-up: `RST`=1 for 5 cycles, `locked`=1 throughout, HOLD_CYCLES=16. Required: `rst_out` falls exactly 19 edges after `RST` release; `lost_cnt`=0.
- Divider: `div`={ch1=3, ch0=0}, free run. Required: `ce[0]` is high on every cycle in RUN; `ce[1]` pulses every 4th cycle, first pulse 4 edges after RUN; a change of ch1 to 1 mid-period applies only after the next pulse.
- Lock loss: drop `locked` for 10 cycles in RUN. Required: `rst_out`=1 and `ce`=0 within 3 edges; `lost_cnt`=1; RUN re-entered 2+1+16 edges after `locked` returns.
- HOLD glitch: drop `locked` for 1 cycle at `hold_cnt`=10. Required: back to WAIT_LOCK, `lost_cnt` increments, full 16-cycle hold repeats.
- Single step: `step_mode`=1, `div`=5, pulse `step` 3 times, holding it 20 cycles each. Required: exactly 3 `ce` pulses per channel, none between steps; `step` pulses before RUN produce none.
- Saturation: 300 lock losses. Required: `lost_cnt`=255; `RST` clears it to 0.
